// File: rtl/sm_regdump_uart.sv
// Debug register-dump transmitter: walks regAddr over the register file and sends
// each captured word as 8 uppercase ASCII hex characters plus CR LF on an 8N1 UART line.
module sm_regdump_uart #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] regData,
  output logic [4:0]  regAddr,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [4:0] ADDR_LAST = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    NEXT
  } state_t;

  state_t            state, stateNxt;
  logic [BAUD_W-1:0] baudCnt, baudNxt;
  logic [2:0]        bitIdx, bitNxt;
  logic [3:0]        charIdx, charNxt;
  logic [31:0]       shadow, shadowNxt;
  logic [4:0]        addrNxt;
  logic              busyNxt;
  logic              txNxt;
  logic [7:0]        txByte;
  logic              baudLast;

  // Character index 0..7 -> hex digit of word (MSB nibble first), 8 -> CR, 9 -> LF
  function automatic logic [7:0] charByte(input logic [31:0] word, input logic [3:0] idx);
    logic [3:0] nib;
    nib = 4'(word >> (5'd28 - {idx[2:0], 2'b00}));
    if (idx == 4'd8) begin
      charByte = 8'h0D;
    end else if (idx == 4'd9) begin
      charByte = 8'h0A;
    end else if (nib < 4'd10) begin
      charByte = 8'h30 + {4'h0, nib};
    end else begin
      charByte = 8'h37 + {4'h0, nib};
    end
  endfunction

  assign baudLast = (baudCnt == BAUD_LAST);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baudCnt <= '0;
      bitIdx  <= '0;
      charIdx <= '0;
      shadow  <= '0;
      regAddr <= '0;
      busy    <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= stateNxt;
      baudCnt <= baudNxt;
      bitIdx  <= bitNxt;
      charIdx <= charNxt;
      shadow  <= shadowNxt;
      regAddr <= addrNxt;
      busy    <= busyNxt;
      tx      <= txNxt;
    end
  end

  // Next-state logic; tx is derived from the next state so the line is registered
  always_comb begin
    stateNxt  = state;
    baudNxt   = baudCnt;
    bitNxt    = bitIdx;
    charNxt   = charIdx;
    shadowNxt = shadow;
    addrNxt   = regAddr;
    busyNxt   = busy;
    txNxt     = 1'b1;
    txByte    = 8'h00;

    case (state)
      IDLE: begin
        addrNxt = '0;
        busyNxt = 1'b0;
        if (start) begin
          stateNxt = SETTLE;
          busyNxt  = 1'b1;
        end
      end
      SETTLE: begin
        stateNxt = CAPTURE;
      end
      CAPTURE: begin
        shadowNxt = regData;
        charNxt   = '0;
        bitNxt    = '0;
        baudNxt   = '0;
        stateNxt  = START_BIT;
      end
      START_BIT: begin
        if (baudLast) begin
          baudNxt  = '0;
          bitNxt   = '0;
          stateNxt = DATA_BITS;
        end else begin
          baudNxt = baudCnt + BAUD_W'(1);
        end
      end
      DATA_BITS: begin
        if (baudLast) begin
          baudNxt = '0;
          if (bitIdx == 3'd7) begin
            stateNxt = STOP_BIT;
          end else begin
            bitNxt = bitIdx + 3'd1;
          end
        end else begin
          baudNxt = baudCnt + BAUD_W'(1);
        end
      end
      STOP_BIT: begin
        if (baudLast) begin
          baudNxt = '0;
          if (charIdx == 4'd9) begin
            stateNxt = NEXT;
          end else begin
            charNxt  = charIdx + 4'd1;
            stateNxt = START_BIT;
          end
        end else begin
          baudNxt = baudCnt + BAUD_W'(1);
        end
      end
      NEXT: begin
        if (regAddr == ADDR_LAST) begin
          addrNxt  = '0;
          busyNxt  = 1'b0;
          stateNxt = IDLE;
        end else begin
          addrNxt  = regAddr + 5'd1;
          stateNxt = SETTLE;
        end
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase

    txByte = charByte(shadowNxt, charNxt);
    if (stateNxt == START_BIT) begin
      txNxt = 1'b0;
    end else if (stateNxt == DATA_BITS) begin
      txNxt = txByte[bitNxt];
    end
  end

endmodule

// File: tb/tb_sm_regdump_uart.sv
// Bench for sm_regdump_uart: a one-register instance for waveform/reset checks and a
// full 32-register instance with a UART receiver checked against an expected-byte queue.
module tb_sm_regdump_uart;

  localparam int unsigned BD = 4;
  localparam int unsigned NR = 32;
  localparam int REG_CYC = 100 * BD + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstOne_n, startOne, txOne, busyOne;
  logic [31:0] regDataOne;
  logic [4:0]  regAddrOne;

  logic        rst_n, start, tx, busy;
  logic [31:0] regData;
  logic [4:0]  regAddr;

  sm_regdump_uart #(.BAUD_DIV(BD), .NUM_REGS(1)) u_one (
    .clk(clk), .rst_n(rstOne_n), .start(startOne), .regData(regDataOne),
    .regAddr(regAddrOne), .tx(txOne), .busy(busyOne)
  );

  sm_regdump_uart #(.BAUD_DIV(BD), .NUM_REGS(NR)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .regData(regData),
    .regAddr(regAddr), .tx(tx), .busy(busy)
  );

  int passCnt  = 0;
  int totalCnt = 0;
  int rxCount  = 0;
  logic [7:0] expQ[$];
  logic [7:0] expOne[$];
  logic       waveOne[0:1023];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pushWord(input bit toOne, input logic [31:0] w);
    logic [3:0] nb;
    logic [7:0] c;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) c = 8'h0D;
      else if (i == 9) c = 8'h0A;
      else begin
        nb = w[31-4*i -: 4];
        c = (nb < 4'd10) ? (8'h30 + 8'(nb)) : (8'h41 + 8'(nb) - 8'd10);
      end
      if (toOne) expOne.push_back(c);
      else expQ.push_back(c);
    end
  endtask

  // Register-file model for the full instance; optionally garbage outside SETTLE/CAPTURE
  logic scramble = 1'b0;
  logic prevBusy = 1'b0;
  int   ph = 0;
  always @(negedge clk) begin
    if (busy === 1'b1) ph = (prevBusy === 1'b1) ? ((ph == REG_CYC - 1) ? 0 : ph + 1) : 0;
    prevBusy = busy;
    if (scramble && busy === 1'b1 && ph >= 2) regData = $urandom;
    else regData = 32'h1000_0000 + 32'(regAddr);
  end

  // UART receiver for the full instance, mid-bit sampling
  logic [7:0] rxByte;
  logic       rxStop;
  logic [7:0] rxExp;
  always begin
    @(negedge clk);
    if (rst_n === 1'b1 && tx === 1'b0) begin
      repeat (2) @(negedge clk);
      chk("rx_start_mid", 32'(tx), 0);
      for (int j = 0; j < 8; j++) begin
        repeat (BD) @(negedge clk);
        rxByte[j] = tx;
      end
      repeat (BD) @(negedge clk);
      rxStop = tx;
      chk("rx_stop_bit", 32'(rxStop), 1);
      chk("rx_expected_avail", 32'(expQ.size() != 0), 1);
      if (expQ.size() != 0) begin
        rxExp = expQ.pop_front();
        chk("rx_byte", 32'(rxByte), 32'(rxExp));
      end
      rxCount++;
      @(negedge clk);
    end
  end

  // One dump of the single-register instance, recorded cycle by cycle and checked frame by frame
  task automatic dumpOne(input logic [31:0] w, input bit checkZeroChar);
    int n;
    logic [7:0] e;
    logic [7:0] dec;
    logic       ok, bv;
    logic [9:0] pat;
    regDataOne = w;
    pushWord(1'b1, w);
    @(negedge clk) startOne = 1'b1;
    @(negedge clk) startOne = 1'b0;
    n = 0;
    while (busyOne === 1'b1 && n < 1000) begin
      waveOne[n] = txOne;
      n++;
      @(negedge clk);
    end
    chk("one_busy_cycles", 32'(n), 32'(REG_CYC));
    chk("one_settle_tx", 32'(waveOne[0]), 1);
    chk("one_capture_tx", 32'(waveOne[1]), 1);
    chk("one_next_tx", 32'(waveOne[REG_CYC-1]), 1);
    for (int f = 0; f < 10; f++) begin
      e = expOne.pop_front();
      ok = 1'b1;
      dec = 8'h00;
      for (int s = 0; s < 10; s++) begin
        bv = (s == 0) ? 1'b0 : ((s == 9) ? 1'b1 : e[s-1]);
        for (int c = 0; c < int'(BD); c++)
          if (waveOne[2 + 40*f + 4*s + c] !== bv) ok = 1'b0;
        if (s >= 1 && s <= 8) dec[s-1] = waveOne[2 + 40*f + 4*s + 2];
      end
      chk("one_frame_byte", 32'(dec), 32'(e));
      chk("one_frame_timing", 32'(ok), 1);
    end
    if (checkZeroChar) begin
      pat = '0;
      for (int k = 0; k < 10; k++) pat = {pat[8:0], waveOne[2 + 4*k + 2]};
      chk("one_char0_bits", 32'(pat), 32'(10'b0000011001));
    end
    chk("one_end_busy", 32'(busyOne), 0);
    chk("one_end_addr", 32'(regAddrOne), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w, steps;
    logic stepOk;
    logic [4:0] last;

    rst_n = 1'b1; rstOne_n = 1'b1;
    start = 1'b0; startOne = 1'b0;
    regDataOne = 32'h0;
    #2;
    rst_n = 1'b0; rstOne_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(regAddr), 0);
    chk("rst_one_tx", 32'(txOne), 1);
    rst_n = 1'b1; rstOne_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_tx", 32'(tx), 1);
    chk("idle_busy", 32'(busy), 0);

    // Asynchronous reset in the middle of a start bit
    @(negedge clk) startOne = 1'b1;
    @(negedge clk) startOne = 1'b0;
    w = 0;
    while (txOne !== 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("abort_tx_low_seen", 32'(txOne), 0);
    @(negedge clk);
    #2 rstOne_n = 1'b0;
    #1;
    chk("abort_tx", 32'(txOne), 1);
    chk("abort_busy", 32'(busyOne), 0);
    chk("abort_addr", 32'(regAddrOne), 0);
    @(negedge clk) rstOne_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_abort_tx", 32'(txOne), 1);
    chk("post_abort_busy", 32'(busyOne), 0);

    dumpOne(32'hDEAD_BEEF, 1'b0);
    repeat (3) @(negedge clk);
    dumpOne(32'h0123_4567, 1'b1);

    // Full dump with start pulses while busy
    for (int a = 0; a < int'(NR); a++) pushWord(1'b0, 32'h1000_0000 + 32'(a));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0; steps = 0; stepOk = 1'b1; last = regAddr;
    while (busy === 1'b1 && n < 20000) begin
      if (regAddr !== last) begin
        if (regAddr !== last + 5'd1) stepOk = 1'b0;
        steps++;
        last = regAddr;
      end
      start = (n % 997 == 500) ? 1'b1 : 1'b0;
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("full_busy_cycles", 32'(n), 32'(int'(NR) * REG_CYC));
    chk("full_addr_steps", 32'(steps), 32'(NR - 1));
    chk("full_addr_step_ok", 32'(stepOk), 1);
    chk("full_end_addr", 32'(regAddr), 0);
    repeat (2) @(negedge clk);
    chk("full_no_restart", 32'(busy), 0);
    chk("full_rx_count", 32'(rxCount), 32'(NR * 10));
    chk("full_queue_empty", 32'(expQ.size()), 0);

    // Scrambled regData after capture, start held high for back-to-back dumps
    scramble = 1'b1;
    for (int a = 0; a < int'(NR); a++) pushWord(1'b0, 32'h1000_0000 + 32'(a));
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_first_cycles", 32'(n), 32'(int'(NR) * REG_CYC));
    chk("b2b_gap_busy", 32'(busy), 0);
    for (int a = 0; a < int'(NR); a++) pushWord(1'b0, 32'h1000_0000 + 32'(a));
    @(negedge clk);
    chk("b2b_restart", 32'(busy), 1);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_second_cycles", 32'(n), 32'(int'(NR) * REG_CYC));
    repeat (2) @(negedge clk);
    chk("b2b_rx_count", 32'(rxCount), 32'(NR * 30));
    chk("b2b_queue_empty", 32'(expQ.size()), 0);
    chk("b2b_end_busy", 32'(busy), 0);
    chk("b2b_end_tx", 32'(tx), 1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/sm_regdump_uart.md
Name: sm_regdump_uart

Overview:
Debug register-dump transmitter that sits on the CPU register read-out port. On a start request it walks regAddr from 0 to NUM_REGS-1 and captures each regData word. Each word is sent over a UART TX line as 8 uppercase ASCII hex characters followed by CR LF. It gives the board a serial view of the whole register file, complementing the switch/LED read-out path.

Parameters:
BAUD_DIV, 434, clk cycles per UART bit (115200 baud at 50 MHz); must be >= 2
NUM_REGS, 32, number of registers dumped, addresses 0..NUM_REGS-1; range 1..32

Ports:
clk      input   1   system clock (CPU-side clock domain)
rst_n    input   1   asynchronous active-low reset
start    input   1   dump request, sampled on rising clk edge
regData  input   32  register contents for current regAddr (combinational read)
regAddr  output  5   register address being read, registered
tx       output  1   UART transmit line, 8N1, idle high, registered
busy     output  1   high while a dump is in progress, registered

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset, applied immediately and asynchronously: tx=1, busy=0, regAddr=0. All counters clear, FSM returns to IDLE.
- A reset mid-frame aborts the dump. No partial frame completion; the line returns high at once.
- FSM states: IDLE, SETTLE, CAPTURE, START_BIT, DATA_BITS, STOP_BIT, NEXT.
- IDLE: busy=0, regAddr=0, tx=1.
  - start=1 at an edge -> SETTLE; busy=1 from the next cycle.
  - start is level-sampled only in IDLE and ignored in every other state.
- SETTLE: one cycle so regData settles for the current regAddr -> CAPTURE.
- CAPTURE: latch regData into a 32-bit shadow register, clear the character index (0..9) -> START_BIT.
- Character index 0..7 selects nibble shadow[31-4i -: 4], MSB nibble first.
  - ASCII encoding: nibble 0-9 -> 0x30+n; nibble A-F -> 0x41+(n-10), uppercase.
  - Index 8 sends 0x0D; index 9 sends 0x0A.
- START_BIT: tx=0 for exactly BAUD_DIV cycles.
- DATA_BITS: 8 bits, LSB first, each held exactly BAUD_DIV cycles.
- STOP_BIT: tx=1 for BAUD_DIV cycles.
  - Then, if index<9: increment index -> START_BIT, so frames are back-to-back with no extra idle.
  - If index==9 -> NEXT.
- NEXT:
  - If regAddr==NUM_REGS-1: regAddr<=0, busy<=0 -> IDLE.
  - Otherwise regAddr<=regAddr+1 -> SETTLE.
- Timing:
  - Frame = 10*BAUD_DIV cycles.
  - Per register = 100*BAUD_DIV + 3 cycles (SETTLE, CAPTURE, NEXT).
  - Dump = NUM_REGS*(100*BAUD_DIV+3) cycles of busy.
- The baud counter is reloaded at every bit boundary, so there is no cumulative drift.
- regData changes after CAPTURE do not affect the word being sent.
- start held high continuously: a new dump begins one cycle after busy falls (IDLE re-samples start).

Test Plan:
1. Reset: assert rst_n=0 mid-bit with tx low -> tx=1, busy=0, regAddr=0 within the same cycle (asynchronous). After release, tx stays 1 with start=0.
2. Single word, BAUD_DIV=4, NUM_REGS=1, regData=0xDEADBEEF, pulse start -> byte stream 0x44 0x45 0x41 0x44 0x42 0x45 0x45 0x46 0x0D 0x0A. busy high for exactly 403 cycles.
3. Bit timing, BAUD_DIV=4:
   - Each start, data and stop bit lasts exactly 4 cycles; bits sent LSB first.
   - First character '0' (0x30) appears as tx 0, 0,0,0,0,1,1,0,0, 1.
   - No gap between consecutive frames.
4. Full dump, NUM_REGS=32, bench returns regData=0x1000_0000+regAddr:
   - regAddr steps 0..31.
   - The 32 lines received read "10000000".."1000001F" with CR LF.
   - regAddr returns to 0 and busy falls after 32*403 cycles.
5. Start ignored while busy: pulse start repeatedly during a dump -> byte count and order unchanged (exactly NUM_REGS*10 bytes), no restart.
6. Capture isolation and back-to-back: change regData every cycle after CAPTURE -> transmitted word equals the value at the CAPTURE edge. Hold start=1 -> the second dump starts one cycle after busy falls.
